// File: rtl/mdec_cmd_sequencer.sv
// Command front-end for the MDEC core: parses host command headers and routes
// payload to the RLE stream, the quant-table port or the cos-table port.
module mdec_cmd_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_nrst,
    input  logic             i_wordValid,
    input  logic [31:0]      i_word,
    output logic             o_wordReady,
    input  logic             i_abort,
    output logic [1:0]       o_bitSetupDepth,
    output logic             o_bitSigned,
    output logic             o_dataWrite,
    output logic [15:0]      o_dataOut,
    input  logic             i_lockPipe,
    input  logic             i_allowLoad,
    input  logic             i_stillIDCT,
    output logic             o_quantWrt,
    output logic [27:0]      o_quantValue,
    output logic [3:0]       o_quantAdr,
    output logic             o_quantTblSelect,
    output logic             o_cosWrite,
    output logic [4:0]       o_cosIndex,
    output logic [25:0]      o_cosVal,
    output logic             o_busy,
    output logic             o_cmdDone,
    output logic [CNT_W-1:0] o_wordsLeft
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEC_LO, S_DEC_HI, S_QUANT, S_COS, S_DRAIN
    } state_t;

    localparam logic [2:0] OP_DECODE = 3'd1;
    localparam logic [2:0] OP_QUANT  = 3'd2;
    localparam logic [2:0] OP_COS    = 3'd3;

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_depth;
    logic             r_signed;
    logic [CNT_W-1:0] r_wordsLeft;
    logic [31:0]      r_hold;
    logic             r_holdValid;
    logic [4:0]       r_row;
    logic             r_drainCnt;
    logic             r_cmdDone;
    logic             r_quantWrt;
    logic [27:0]      r_quantValue;
    logic [3:0]       r_quantAdr;
    logic             r_quantTblSelect;
    logic             r_cosWrite;
    logic [4:0]       r_cosIndex;
    logic [25:0]      r_cosVal;

    logic             w_emit;
    logic             w_drainOk;
    logic             w_ready;
    logic             w_accept;
    logic             w_moreWords;
    logic [2:0]       w_opcode;

    assign w_emit      = r_holdValid & i_allowLoad & ~i_lockPipe;
    assign w_drainOk   = ~i_stillIDCT & i_allowLoad;
    assign w_moreWords = (r_wordsLeft != '0);
    assign w_opcode    = i_word[31:29];

    // The HI emit frees the hold register in the same cycle, so ready can
    // rise there and a new word lands without a bubble.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_ready = 1'b1;
            S_DEC_LO: w_ready = w_moreWords & ~r_holdValid;
            S_DEC_HI: w_ready = w_moreWords & (~r_holdValid | w_emit);
            S_QUANT:  w_ready = w_moreWords;
            S_COS:    w_ready = w_moreWords;
            default:  w_ready = 1'b0;
        endcase
    end

    assign o_wordReady = w_ready & i_nrst & ~i_abort;
    assign w_accept    = i_wordValid & o_wordReady;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_opcode)
                        OP_DECODE: w_nextState = (i_word[15:0] != 16'd0) ? S_DEC_LO : S_DRAIN;
                        OP_QUANT:  w_nextState = S_QUANT;
                        OP_COS:    w_nextState = S_COS;
                        default:   w_nextState = S_IDLE;
                    endcase
                end
            end
            S_DEC_LO: if (w_emit) w_nextState = S_DEC_HI;
            S_DEC_HI: if (w_emit) w_nextState = w_moreWords ? S_DEC_LO : S_DRAIN;
            S_QUANT, S_COS: begin
                if (w_accept && r_wordsLeft == CNT_W'(1)) w_nextState = S_DRAIN;
            end
            S_DRAIN: if (w_drainOk && r_drainCnt) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (i_abort) w_nextState = S_IDLE;
    end

    // Datapath: strobes are single-cycle and default low every clock.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_depth          <= '0;
            r_signed         <= 1'b0;
            r_wordsLeft      <= '0;
            r_hold           <= '0;
            r_holdValid      <= 1'b0;
            r_row            <= '0;
            r_drainCnt       <= 1'b0;
            r_cmdDone        <= 1'b0;
            r_quantWrt       <= 1'b0;
            r_quantValue     <= '0;
            r_quantAdr       <= '0;
            r_quantTblSelect <= 1'b0;
            r_cosWrite       <= 1'b0;
            r_cosIndex       <= '0;
            r_cosVal         <= '0;
        end else begin
            r_cmdDone  <= 1'b0;
            r_quantWrt <= 1'b0;
            r_cosWrite <= 1'b0;
            if (i_abort) begin
                r_wordsLeft <= '0;
                r_hold      <= '0;
                r_holdValid <= 1'b0;
                r_row       <= '0;
                r_drainCnt  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_depth  <= i_word[28:27];
                            r_signed <= i_word[26];
                            r_row    <= '0;
                            case (w_opcode)
                                OP_DECODE: r_wordsLeft <= CNT_W'(i_word[15:0]);
                                OP_QUANT:  r_wordsLeft <= i_word[0] ? CNT_W'(32) : CNT_W'(16);
                                OP_COS:    r_wordsLeft <= CNT_W'(32);
                                default:   r_cmdDone   <= 1'b1;
                            endcase
                        end
                    end
                    S_DEC_LO, S_DEC_HI: begin
                        if (r_state == S_DEC_HI && w_emit) r_holdValid <= 1'b0;
                        if (w_accept) begin
                            r_hold      <= i_word;
                            r_holdValid <= 1'b1;
                            r_wordsLeft <= r_wordsLeft - CNT_W'(1);
                        end
                    end
                    S_QUANT: begin
                        if (w_accept) begin
                            r_quantWrt       <= 1'b1;
                            r_quantValue     <= {i_word[30:24], i_word[22:16], i_word[14:8], i_word[6:0]};
                            r_quantAdr       <= r_row[3:0];
                            r_quantTblSelect <= r_row[4];
                            r_row            <= r_row + 5'd1;
                            r_wordsLeft      <= r_wordsLeft - CNT_W'(1);
                        end
                    end
                    S_COS: begin
                        if (w_accept) begin
                            r_cosWrite  <= 1'b1;
                            r_cosVal    <= {i_word[28:16], i_word[12:0]};
                            r_cosIndex  <= r_row;
                            r_row       <= r_row + 5'd1;
                            r_wordsLeft <= r_wordsLeft - CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (w_drainOk) begin
                            r_drainCnt <= ~r_drainCnt;
                            if (r_drainCnt) r_cmdDone <= 1'b1;
                        end else begin
                            r_drainCnt <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_bitSetupDepth  = r_depth;
    assign o_bitSigned      = r_signed;
    assign o_dataWrite      = w_emit;
    assign o_dataOut        = (r_state == S_DEC_HI) ? r_hold[31:16] : r_hold[15:0];
    assign o_quantWrt       = r_quantWrt;
    assign o_quantValue     = r_quantValue;
    assign o_quantAdr       = r_quantAdr;
    assign o_quantTblSelect = r_quantTblSelect;
    assign o_cosWrite       = r_cosWrite;
    assign o_cosIndex       = r_cosIndex;
    assign o_cosVal         = r_cosVal;
    assign o_busy           = (r_state != S_IDLE);
    assign o_cmdDone        = r_cmdDone;
    assign o_wordsLeft      = r_wordsLeft;

endmodule

// File: tb/tb_mdec_cmd_sequencer.sv
// Directed bench for mdec_cmd_sequencer: decode, stall, quant, cos, empty
// decode with IDCT drain, NOP, abort and mid-command reset.
module tb_mdec_cmd_sequencer;

    logic        clk;
    logic        i_nrst;
    logic        i_wordValid;
    logic [31:0] i_word;
    logic        o_wordReady;
    logic        i_abort;
    logic [1:0]  o_bitSetupDepth;
    logic        o_bitSigned;
    logic        o_dataWrite;
    logic [15:0] o_dataOut;
    logic        i_lockPipe;
    logic        i_allowLoad;
    logic        i_stillIDCT;
    logic        o_quantWrt;
    logic [27:0] o_quantValue;
    logic [3:0]  o_quantAdr;
    logic        o_quantTblSelect;
    logic        o_cosWrite;
    logic [4:0]  o_cosIndex;
    logic [25:0] o_cosVal;
    logic        o_busy;
    logic        o_cmdDone;
    logic [15:0] o_wordsLeft;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int doneCount  = 0;
    logic [15:0] dataQ[$];
    int          dataCyc[$];
    logic [32:0] quantQ[$];
    logic [30:0] cosQ[$];

    mdec_cmd_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .i_nrst(i_nrst), .i_wordValid(i_wordValid), .i_word(i_word),
        .o_wordReady(o_wordReady), .i_abort(i_abort),
        .o_bitSetupDepth(o_bitSetupDepth), .o_bitSigned(o_bitSigned),
        .o_dataWrite(o_dataWrite), .o_dataOut(o_dataOut),
        .i_lockPipe(i_lockPipe), .i_allowLoad(i_allowLoad), .i_stillIDCT(i_stillIDCT),
        .o_quantWrt(o_quantWrt), .o_quantValue(o_quantValue), .o_quantAdr(o_quantAdr),
        .o_quantTblSelect(o_quantTblSelect), .o_cosWrite(o_cosWrite),
        .o_cosIndex(o_cosIndex), .o_cosVal(o_cosVal), .o_busy(o_busy),
        .o_cmdDone(o_cmdDone), .o_wordsLeft(o_wordsLeft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cycle++;
        if (o_dataWrite) begin
            dataQ.push_back(o_dataOut);
            dataCyc.push_back(cycle);
            checkOutput("dataWrite inside command", {63'd0, o_busy}, 64'd1);
        end
        if (o_quantWrt) quantQ.push_back({o_quantTblSelect, o_quantAdr, o_quantValue});
        if (o_cosWrite) cosQ.push_back({o_cosIndex, o_cosVal});
        if (o_cmdDone)  doneCount++;
    end

    // Called and returning at posedge+1; presents one word until accepted.
    task automatic applyStimulus(input logic [31:0] w);
        logic acc;
        acc = 1'b0;
        i_wordValid = 1'b1;
        i_word      = w;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = o_wordReady;
            @(posedge clk);
            #1;
        end
        i_wordValid = 1'b0;
        if (!acc) checkOutput("handshake timeout", 64'd0, 64'd1);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        dataQ.delete();
        dataCyc.delete();
        quantQ.delete();
        cosQ.delete();
        doneCount = 0;
    endtask

    function automatic logic [16:0] dataAt(input int i);
        return (i < dataQ.size()) ? {1'b0, dataQ[i]} : 17'h10000;
    endfunction

    task automatic checkDecode(input string tag, input logic [15:0] exp0, input logic [15:0] exp1,
                               input logic [15:0] exp2, input logic [15:0] exp3, input int n);
        logic [15:0] expv [4];
        expv = '{exp0, exp1, exp2, exp3};
        checkOutput({tag, " strobe count"}, 64'(dataQ.size()), 64'(n));
        for (int i = 0; i < n; i++)
            checkOutput({tag, " halfword"}, 64'(dataAt(i)), {48'd0, expv[i]});
    endtask

    initial begin
        int edges;
        i_nrst = 1'b0; i_wordValid = 1'b0; i_word = '0; i_abort = 1'b0;
        i_lockPipe = 1'b0; i_allowLoad = 1'b1; i_stillIDCT = 1'b0;

        #12;
        checkOutput("reset wordReady", {63'd0, o_wordReady}, 64'd0);
        checkOutput("reset busy", {63'd0, o_busy}, 64'd0);
        checkOutput("reset cmdDone", {63'd0, o_cmdDone}, 64'd0);
        checkOutput("reset depth", {62'd0, o_bitSetupDepth}, 64'd0);
        checkOutput("reset wordsLeft", {48'd0, o_wordsLeft}, 64'd0);
        checkOutput("reset strobes", {61'd0, o_dataWrite, o_quantWrt, o_cosWrite}, 64'd0);
        @(posedge clk); #1;
        i_nrst = 1'b1;
        #1;
        checkOutput("idle wordReady", {63'd0, o_wordReady}, 64'd1);

        $display("[TB] decode, no stalls");
        clearLogs();
        applyStimulus(32'h3000_0002);
        checkOutput("dec1 depth", {62'd0, o_bitSetupDepth}, 64'd2);
        checkOutput("dec1 wordsLeft", {48'd0, o_wordsLeft}, 64'd2);
        applyStimulus(32'hBBBB_AAAA);
        applyStimulus(32'hDDDD_CCCC);
        waitCycles(8);
        checkDecode("dec1", 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 4);
        for (int i = 1; i < 4; i++)
            checkOutput("dec1 back-to-back", 64'((i < dataCyc.size()) ? dataCyc[i] - dataCyc[i-1] : 99), 64'd1);
        checkOutput("dec1 cmdDone count", 64'(doneCount), 64'd1);
        checkOutput("dec1 idle after", {63'd0, o_busy}, 64'd0);

        $display("[TB] decode with stall on second halfword");
        clearLogs();
        applyStimulus(32'h3000_0002);
        applyStimulus(32'hBBBB_AAAA);
        fork
            applyStimulus(32'hDDDD_CCCC);
            begin
                @(posedge clk); #1;
                i_lockPipe = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall dataOut", {48'd0, o_dataOut}, 64'hBBBB);
                    checkOutput("stall dataWrite", {63'd0, o_dataWrite}, 64'd0);
                    checkOutput("stall wordReady", {63'd0, o_wordReady}, 64'd0);
                    @(posedge clk);
                end
                #1;
                i_lockPipe = 1'b0;
            end
        join
        waitCycles(8);
        checkDecode("dec2", 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 4);
        checkOutput("dec2 cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] quant colour table");
        clearLogs();
        applyStimulus(32'h4000_0001);
        checkOutput("quant wordsLeft", {48'd0, o_wordsLeft}, 64'd32);
        for (int k = 0; k < 32; k++) applyStimulus(32'h8180_8180 + 32'(k));
        waitCycles(6);
        checkOutput("quant strobe count", 64'(quantQ.size()), 64'd32);
        for (int k = 0; k < 32 && k < quantQ.size(); k++)
            checkOutput("quant entry", {31'd0, quantQ[k]},
                        {31'd0, (k >= 16), 4'(k % 16), 28'h020_0080 + 28'(k)});
        checkOutput("quant cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] cos table");
        clearLogs();
        applyStimulus(32'h6000_0000);
        for (int k = 0; k < 32; k++) applyStimulus(32'hFFFF_FFFF);
        waitCycles(6);
        checkOutput("cos strobe count", 64'(cosQ.size()), 64'd32);
        for (int k = 0; k < 32 && k < cosQ.size(); k++)
            checkOutput("cos entry", {33'd0, cosQ[k]}, {33'd0, 5'(k), 26'h3FF_FFFF});
        checkOutput("cos cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] empty decode waiting on IDCT");
        clearLogs();
        i_stillIDCT = 1'b1;
        applyStimulus(32'h2000_0000);
        checkOutput("empty depth", {62'd0, o_bitSetupDepth}, 64'd0);
        waitCycles(10);
        checkOutput("empty still busy", {63'd0, o_busy}, 64'd1);
        checkOutput("drain wordReady", {63'd0, o_wordReady}, 64'd0);
        checkOutput("empty no early done", 64'(doneCount), 64'd0);
        i_stillIDCT = 1'b0;
        edges = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            edges++;
            if (o_cmdDone) break;
        end
        checkOutput("empty done latency", 64'(edges), 64'd2);
        waitCycles(2);
        checkOutput("empty no dataWrite", 64'(dataQ.size()), 64'd0);
        checkOutput("empty cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] nop header");
        clearLogs();
        applyStimulus(32'hE000_0000);
        checkOutput("nop cmdDone", {63'd0, o_cmdDone}, 64'd1);
        checkOutput("nop stays idle", {63'd0, o_busy}, 64'd0);
        waitCycles(2);
        checkOutput("nop cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] abort mid decode");
        clearLogs();
        i_allowLoad = 1'b0;
        applyStimulus(32'h2800_0003);
        applyStimulus(32'h1111_2222);
        i_wordValid = 1'b1;
        i_word = 32'h3333_4444;
        i_abort = 1'b1;
        @(negedge clk);
        checkOutput("abort wordReady", {63'd0, o_wordReady}, 64'd0);
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_wordValid = 1'b0;
        checkOutput("abort idle", {63'd0, o_busy}, 64'd0);
        checkOutput("abort wordsLeft", {48'd0, o_wordsLeft}, 64'd0);
        checkOutput("abort keeps depth", {62'd0, o_bitSetupDepth}, 64'd1);
        i_allowLoad = 1'b1;
        waitCycles(5);
        checkOutput("abort no strobes", 64'(dataQ.size()), 64'd0);
        checkOutput("abort no cmdDone", 64'(doneCount), 64'd0);
        clearLogs();
        applyStimulus(32'h3C00_0001);
        checkOutput("post-abort depth", {62'd0, o_bitSetupDepth}, 64'd3);
        checkOutput("post-abort signed", {63'd0, o_bitSigned}, 64'd1);
        applyStimulus(32'h1234_5678);
        waitCycles(8);
        checkDecode("post-abort", 16'h5678, 16'h1234, 16'h0000, 16'h0000, 2);
        checkOutput("post-abort cmdDone count", 64'(doneCount), 64'd1);

        $display("[TB] reset mid command");
        applyStimulus(32'h3C00_0004);
        checkOutput("pre-reset busy", {63'd0, o_busy}, 64'd1);
        i_nrst = 1'b0;
        #2;
        checkOutput("mid-reset busy", {63'd0, o_busy}, 64'd0);
        checkOutput("mid-reset depth", {62'd0, o_bitSetupDepth}, 64'd0);
        checkOutput("mid-reset signed", {63'd0, o_bitSigned}, 64'd0);
        checkOutput("mid-reset wordReady", {63'd0, o_wordReady}, 64'd0);
        @(posedge clk); #1;
        i_nrst = 1'b1;
        waitCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdec_cmd_sequencer.md
Name: mdec_cmd_sequencer

Overview:
Command front-end for the MDEC core. It consumes 32-bit host words from a valid/ready stream, parses command headers, and sequences the payload. Decode payload goes to the core RLE input as 16-bit halfwords. Quant payload goes to the quant-table load port and cosine payload to the cos-table load port. The block holds the pixel format and sign setup stable for the whole command, then waits for the IDCT to drain before reporting completion.

Parameters:
CNT_W, 16, width of the header payload word count and of o_wordsLeft.

Ports:
clk  in  1  system clock
i_nrst  in  1  asynchronous active-low reset
i_wordValid  in  1  host word available
i_word  in  32  host word (header or payload)
o_wordReady  out  1  word accepted when i_wordValid & o_wordReady
i_abort  in  1  synchronous abort; return to IDLE
o_bitSetupDepth  out  2  pixel format to core (0=4b, 1=8b, 2=24b, 3=15b)
o_bitSigned  out  1  signed output to core
o_dataWrite  out  1  RLE halfword strobe to core
o_dataOut  out  16  RLE halfword
i_lockPipe  in  1  core stream stall
i_allowLoad  in  1  core can accept matrix data
i_stillIDCT  in  1  IDCT busy
o_quantWrt  out  1  quant write strobe
o_quantValue  out  28  four 7-bit quant entries
o_quantAdr  out  4  quant row address
o_quantTblSelect  out  1  0 = luma, 1 = chroma
o_cosWrite  out  1  cos write strobe
o_cosIndex  out  5  cos row index
o_cosVal  out  26  two 13-bit cos entries
o_busy  out  1  command in progress
o_cmdDone  out  1  one-cycle pulse at command completion
o_wordsLeft  out  CNT_W  payload words still expected

Behaviour:
- Reset values. All outputs are 0; state is IDLE; o_wordReady is 0 during reset.
- Header layout:
  - [31:29] opcode: 1 = DECODE, 2 = QUANT, 3 = COS, other = NOP.
  - [28:27] depth; [26] signed.
  - [15:0] DECODE word count.
  - [0] QUANT colour flag.
- States: IDLE, DEC_LO, DEC_HI, QUANT, COS, DRAIN.
- IDLE:
  - o_wordReady = 1.
  - On accept, latch opcode, depth and signed; o_bitSetupDepth and o_bitSigned update here only.
  - DECODE with count > 0: load count, go to DEC_LO with o_wordReady = 1 for the first payload word.
  - DECODE with count = 0: go to DRAIN.
  - QUANT: count = 32 if colour flag else 16, go to QUANT.
  - COS: count = 32, go to COS.
  - NOP: pulse o_cmdDone next cycle, stay in IDLE.
- DEC_LO / DEC_HI:
  - A payload word is accepted into a 32-bit hold register only when the hold register is empty; each accept decrements o_wordsLeft.
  - o_dataWrite = holdValid & i_allowLoad & !i_lockPipe. This is combinational from registered state.
  - DEC_LO emits word[15:0], then moves to DEC_HI; DEC_HI emits word[31:16].
  - Hold is freed on the HI emit. In that same cycle o_wordReady = 1, allowing back-to-back accept with zero bubble.
  - After the HI emit of the last word (wordsLeft = 0), go to DRAIN.
  - A stall holds o_dataOut stable.
- QUANT (one word per cycle, o_wordReady = 1, registered strobe one cycle after accept):
  - o_quantValue = {w[30:24], w[22:16], w[14:8], w[6:0]}.
  - Row counter r runs 0..31: o_quantAdr = r[3:0], o_quantTblSelect = r[4].
  - After the last word go to DRAIN.
- COS (one word per cycle, o_wordReady = 1, registered strobe one cycle after accept):
  - o_cosVal = {w[28:16], w[12:0]}; o_cosIndex = row 0..31.
  - After the last word go to DRAIN.
- DRAIN:
  - o_wordReady = 0.
  - Leave when !i_stillIDCT & i_allowLoad for 2 consecutive cycles; pulse o_cmdDone and go to IDLE.
- o_busy = (state != IDLE).
- i_abort, in any state, takes priority over a simultaneous accept:
  - next cycle: IDLE, hold cleared, counters cleared, all strobes 0, no o_cmdDone;
  - depth and signed keep their last value.
- Reset asserted mid-command behaves like abort and additionally clears depth and signed.
- No core strobe (o_dataWrite, o_quantWrt, o_cosWrite) is ever asserted outside its own command.

Test Plan:
- DECODE header 0x3000_0002 (depth 2, signed 0, 2 words), words 0xBBBB_AAAA and 0xDDDD_CCCC, no stalls -> o_dataOut AAAA, BBBB, CCCC, DDDD on 4 consecutive strobes; o_bitSetupDepth = 2; one o_cmdDone after the IDCT drains.
- Same decode with i_lockPipe high for 3 cycles during the BBBB emit -> BBBB held stable, no extra strobe, o_wordReady = 0 while the hold is full, output order unchanged.
- QUANT colour header 0x4000_0001 plus 32 words where word k = 0x8180_8180 + k -> 32 o_quantWrt pulses; adr 0..15 with tblSel 0, then 0..15 with tblSel 1; bit 7 of every byte stripped from o_quantValue.
- COS header 0x6000_0000 plus 32 words 0xFFFF_FFFF -> 32 o_cosWrite pulses, index 0..31, o_cosVal = 0x3FF_FFFF.
- DECODE with count 0 while i_stillIDCT = 1 for 10 cycles -> no o_dataWrite; o_cmdDone exactly 2 cycles after i_stillIDCT falls (with i_allowLoad = 1).
- i_abort asserted mid-decode (hold full, i_wordValid = 1) -> IDLE next cycle, no strobes, no o_cmdDone; next header decoded correctly.
